// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//   Control FSM for an oversampling UART receiver. It detects the start bit,
//   counts oversample edges per bit, steers the external sampler and
//   deserializer, checks parity and stop bit, and flags a good frame.
//
// Ports
//   clk          in   receive clock, all logic on the rising edge
//   RST          in   synchronous active-high reset
//   RX_IN        in   serial line (idle high), only looked at while IDLE
//   Prescale[5:0]in   oversampling ratio 8/16/32 (anything else -> 8)
//   PAR_EN       in   frame carries a parity bit
//   PAR_TYP      in   0 = even parity, 1 = odd parity
//   sampled_bit  in   sampler result, valid when edge_cnt == mid
//   P_DATA[7:0]  in   deserializer byte
//   edge_cnt[4:0]out  oversample edge counter within the current bit
//   dat_samp_en  out  sampler enable (every state but IDLE)
//   deser_en     out  deserializer shift enable (DATA only)
//   data_valid   out  one-cycle pulse, coincident with edge_cnt == last of STOP
//   par_err      out  parity error, held until the next start detect
//   stp_err      out  stop bit error, held until the next start detect
// -----------------------------------------------------------------------------
module uart_rx_fsm (
  input  logic       clk,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       sampled_bit,
  input  logic [7:0] P_DATA,
  output logic [4:0] edge_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Expected parity bit: XOR of the data, inverted for odd parity.
  function automatic logic parity_expected(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e     state_q, state_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] p_l_q, p_l_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;
  logic       armed_q, armed_d;
  logic       dat_samp_en_q, dat_samp_en_d;
  logic       deser_en_q, deser_en_d;
  logic       data_valid_q, data_valid_d;

  logic [4:0] mid_s;
  logic [4:0] last_s;
  logic [4:0] pre_last_s;
  logic       at_mid_s;
  logic       at_last_s;

  // Bit-period landmarks derived from the latched prescale. For P_L = 32 the
  // low five bits are 0, so the 5-bit subtraction wraps to the right value.
  always_comb begin
    mid_s      = p_l_q[5:1];
    last_s     = p_l_q[4:0] - 5'd1;
    pre_last_s = p_l_q[4:0] - 5'd2;
    at_mid_s   = (edge_cnt_q == mid_s);
    at_last_s  = (edge_cnt_q == last_s);
  end

  // Next-state, counter, flag and output decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    p_l_d     = p_l_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    // A line held low through reset must go high once before a start counts.
    armed_d   = armed_q | RX_IN;

    if (state_q == IDLE) begin
      edge_cnt_d = 5'd0;
    end else if (at_last_s) begin
      edge_cnt_d = 5'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        if (armed_q && !RX_IN) begin
          state_d   = START;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          case (Prescale)
            6'd8, 6'd16, 6'd32: p_l_d = Prescale;
            default:            p_l_d = 6'd8;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (at_mid_s && sampled_bit) begin
          // Start bit did not hold low to mid-bit: treat as a glitch.
          state_d    = IDLE;
          edge_cnt_d = 5'd0;
          bit_cnt_d  = 3'd0;
        end else if (at_last_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (at_last_s) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = PAR_EN ? PARITY : STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (at_mid_s) begin
          par_err_d = (sampled_bit != parity_expected(P_DATA, PAR_TYP));
        end else begin
          par_err_d = par_err_q;
        end
        if (at_last_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (at_mid_s) begin
          stp_err_d = ~sampled_bit;
        end else begin
          stp_err_d = stp_err_q;
        end
        if (at_last_s) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = 5'd0;
        bit_cnt_d  = 3'd0;
      end
    endcase

    dat_samp_en_d = (state_d != IDLE);
    deser_en_d    = (state_d == DATA);
    // Registered one cycle early so the pulse lines up with edge_cnt == last.
    // The stop sample (at mid) has already landed in stp_err_q by then.
    data_valid_d  = (state_q == STOP) && (edge_cnt_q == pre_last_s) &&
                    !par_err_q && !stp_err_q;
  end

  // State, counters, latched prescale, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= IDLE;
      edge_cnt_q    <= 5'd0;
      bit_cnt_q     <= 3'd0;
      p_l_q         <= 6'd8;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      armed_q       <= 1'b0;
      dat_samp_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      p_l_q         <= p_l_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      armed_q       <= armed_d;
      dat_samp_en_q <= dat_samp_en_d;
      deser_en_q    <= deser_en_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign dat_samp_en = dat_samp_en_q;
  assign deser_en    = deser_en_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Directed bench for uart_rx_fsm. The bench plays the sampler (drives
//   sampled_bit per bit period) and a simple deserializer (shifts sampled_bit
//   LSB-first into P_DATA when deser_en is high at mid-bit).
//   Cycle k of a frame is the cycle following the k-th rising edge after the
//   start-detect edge counted from 1, so edge_cnt = (k-1) % P and the good
//   frame pulse lands on cycle P * (10 + PAR_EN).
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic [7:0] P_DATA;
  logic [4:0] edge_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks   = 0;
  int failures = 0;
  int cur_ps   = 8;
  logic [7:0] deser_sh = 8'h00;

  uart_rx_fsm dut (
    .clk         (clk),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .edge_cnt    (edge_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 clk = ~clk;

  // Stand-in deserializer: LSB-first shift at mid-bit while enabled.
  always @(posedge clk) begin
    if (deser_en && edge_cnt == 5'(cur_ps / 2)) deser_sh <= {sampled_bit, deser_sh[7:1]};
  end
  assign P_DATA = deser_sh;

  // Drives one frame starting just after a rising edge with the DUT idle.
  // rst_at != 0 pulses RST during that cycle and forces the line high after.
  task automatic run_frame(input logic [7:0] data, input logic pen, input logic pbit,
                           input logic sbit, input logic [5:0] ps_in, input int period,
                           input int rst_at, output int dv_cnt, output int dv_at,
                           output logic [7:0] dv_data, output int bad,
                           output logic [1:0] flags1, output logic [9:0] rst_snap);
    int   total;
    int   seg;
    logic bitv;
    total = period * (10 + int'(pen));
    cur_ps = period;
    Prescale = ps_in; PAR_EN = pen; RX_IN = 1'b0; sampled_bit = 1'b0;
    dv_cnt = 0; dv_at = 0; dv_data = 8'h00; bad = 0; flags1 = 2'b11; rst_snap = 10'h3FF;
    @(posedge clk);
    for (int k = 1; k <= total; k++) begin
      #1;
      seg = (k - 1) / period;
      if (seg == 0) bitv = 1'b0;
      else if (seg <= 8) bitv = data[seg-1];
      else if (pen && seg == 9) bitv = pbit;
      else bitv = sbit;
      sampled_bit = bitv;
      Prescale = ~ps_in;
      RST = (rst_at != 0 && k == rst_at) ? 1'b1 : 1'b0;
      RX_IN = (rst_at != 0 && k >= rst_at) ? 1'b1 : bitv;
      @(negedge clk);
      if (data_valid) begin dv_cnt++; dv_at = k; dv_data = P_DATA; end
      if (k == 1) flags1 = {par_err, stp_err};
      if (rst_at != 0 && k == rst_at + 1)
        rst_snap = {edge_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err};
      if (rst_at == 0 || k <= rst_at) begin
        if (edge_cnt !== 5'((k - 1) % period) || dat_samp_en !== 1'b1 ||
            deser_en !== ((seg >= 1 && seg <= 8) ? 1'b1 : 1'b0)) bad++;
      end
      @(posedge clk);
    end
    #1;
    RX_IN = 1'b1; sampled_bit = 1'b1; Prescale = ps_in;
  endtask

  int         dv_cnt, dv_at, bad;
  logic [7:0] dv_data;
  logic [1:0] flags1;
  logic [9:0] rst_snap;

  task automatic test_reset();
    int early;
    RST = 1'b1; RX_IN = 1'b0; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; sampled_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (edge_cnt !== 5'd0) begin failures++; $display("FAIL reset_edge_cnt got=%0d exp=0", edge_cnt); end
    checks++; if (dat_samp_en !== 1'b0) begin failures++; $display("FAIL reset_dat_samp_en got=%b exp=0", dat_samp_en); end
    checks++; if (deser_en !== 1'b0) begin failures++; $display("FAIL reset_deser_en got=%b exp=0", deser_en); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {par_err, stp_err}); end
    // Line held low across reset release must not start a frame.
    RST = 1'b0;
    early = 0;
    repeat (4) begin
      @(negedge clk);
      if (dat_samp_en !== 1'b0 || edge_cnt !== 5'd0) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL reset_no_stale_start got=%0d busy cycles exp=0", early); end
    RX_IN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_frame(8'hA5, 1'b0, 1'b0, 1'b1, 6'd8, 8, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 1) begin failures++; $display("FAIL basic_dv_cnt got=%0d exp=1", dv_cnt); end
    checks++; if (dv_at !== 80) begin failures++; $display("FAIL basic_dv_cycle got=%0d exp=80", dv_at); end
    checks++; if (dv_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", dv_data); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL basic_timing got=%0d bad cycles exp=0", bad); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {par_err, stp_err}); end
    // Illegal prescale falls back to 8.
    run_frame(8'h96, 1'b0, 1'b0, 1'b1, 6'd12, 8, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_at !== 80 || bad !== 0) begin failures++; $display("FAIL illegal_ps got cycle=%0d bad=%0d exp cycle=80 bad=0", dv_at, bad); end
    checks++; if (dv_data !== 8'h96) begin failures++; $display("FAIL illegal_ps_data got=%h exp=96", dv_data); end
  endtask

  task automatic test_parity_err();
    PAR_TYP = 1'b0;
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 6'd16, 16, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 0) begin failures++; $display("FAIL parity_dv_cnt got=%0d exp=0", dv_cnt); end
    checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL parity_par_err got=%b exp=1", par_err); end
    checks++; if (stp_err !== 1'b0) begin failures++; $display("FAIL parity_stp_err got=%b exp=0", stp_err); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL parity_timing got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_glitch();
    int desr;
    int idle_bad;
    desr = 0; idle_bad = 0;
    cur_ps = 32; Prescale = 6'd32; PAR_EN = 1'b0; RX_IN = 1'b0; sampled_bit = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      #1;
      RX_IN = (k < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (deser_en !== 1'b0) desr++;
      if (k == 17) begin
        checks++; if (edge_cnt !== 5'd16 || dat_samp_en !== 1'b1) begin failures++; $display("FAIL glitch_mid got edge=%0d en=%b exp edge=16 en=1", edge_cnt, dat_samp_en); end
      end
      if (k == 18) begin
        checks++; if (edge_cnt !== 5'd0 || dat_samp_en !== 1'b0) begin failures++; $display("FAIL glitch_idle got edge=%0d en=%b exp edge=0 en=0", edge_cnt, dat_samp_en); end
      end
      if (k > 18 && (edge_cnt !== 5'd0 || dat_samp_en !== 1'b0)) idle_bad++;
      @(posedge clk);
    end
    #1;
    checks++; if (desr !== 0) begin failures++; $display("FAIL glitch_deser got=%0d cycles exp=0", desr); end
    checks++; if (idle_bad !== 0) begin failures++; $display("FAIL glitch_stays_idle got=%0d busy cycles exp=0", idle_bad); end
    checks++; if ({par_err, stp_err} !== 2'b00) begin failures++; $display("FAIL glitch_flags got=%b exp=00", {par_err, stp_err}); end
  endtask

  task automatic test_stop_err();
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 6'd8, 8, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 0) begin failures++; $display("FAIL stop_dv_cnt got=%0d exp=0", dv_cnt); end
    checks++; if (stp_err !== 1'b1) begin failures++; $display("FAIL stop_stp_err got=%b exp=1", stp_err); end
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL stop_par_err got=%b exp=0", par_err); end
    run_frame(8'hC3, 1'b0, 1'b0, 1'b1, 6'd8, 8, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (flags1 !== 2'b00) begin failures++; $display("FAIL stop_clear_on_start got=%b exp=00", flags1); end
    checks++; if (dv_cnt !== 1 || dv_data !== 8'hC3) begin failures++; $display("FAIL stop_next_frame got cnt=%0d data=%h exp cnt=1 data=c3", dv_cnt, dv_data); end
  endtask

  task automatic test_back_to_back();
    PAR_TYP = 1'b1;
    run_frame(8'h00, 1'b1, 1'b1, 1'b1, 6'd16, 16, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 1 || dv_at !== 176) begin failures++; $display("FAIL b2b_first_dv got cnt=%0d cycle=%0d exp cnt=1 cycle=176", dv_cnt, dv_at); end
    checks++; if (dv_data !== 8'h00) begin failures++; $display("FAIL b2b_first_data got=%h exp=00", dv_data); end
    run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 6'd16, 16, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 1 || dv_at !== 176) begin failures++; $display("FAIL b2b_second_dv got cnt=%0d cycle=%0d exp cnt=1 cycle=176", dv_cnt, dv_at); end
    checks++; if (dv_data !== 8'hFF) begin failures++; $display("FAIL b2b_second_data got=%h exp=ff", dv_data); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_second_timing got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    // Cycle 43 at P=8 is data bit index 4.
    run_frame(8'h77, 1'b0, 1'b0, 1'b1, 6'd8, 8, 43, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (rst_snap !== 10'h000) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=000", rst_snap); end
    checks++; if (dv_cnt !== 0) begin failures++; $display("FAIL rst_mid_dv_cnt got=%0d exp=0", dv_cnt); end
    run_frame(8'h19, 1'b0, 1'b0, 1'b1, 6'd8, 8, 0, dv_cnt, dv_at, dv_data, bad, flags1, rst_snap);
    checks++; if (dv_cnt !== 1 || dv_at !== 80 || dv_data !== 8'h19) begin failures++; $display("FAIL rst_mid_recover got cnt=%0d cycle=%0d data=%h exp cnt=1 cycle=80 data=19", dv_cnt, dv_at, dv_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
